// File: rtl/cache_8way.sv
// 4-set x 8-way data cache, 16-byte lines, FIFO replacement, two-edge lookup/data phases.
// Whole cache state is loaded from the init_* snapshot ports on reset; refills come from dataIn.
module cache_8way (
  input  logic         clk,
  input  logic         reset,
  input  logic [25:0]  tagIn,
  input  logic [1:0]   index,
  input  logic [3:0]   offset,
  input  logic         cycle_en,
  input  logic         rw,
  input  logic [127:0] dataIn,
  input  logic [7:0]   dataByteIn,
  input  logic [3:0]   init_dirty0, init_dirty1, init_dirty2, init_dirty3,
  input  logic [3:0]   init_dirty4, init_dirty5, init_dirty6, init_dirty7,
  input  logic [3:0]   init_valid0, init_valid1, init_valid2, init_valid3,
  input  logic [3:0]   init_valid4, init_valid5, init_valid6, init_valid7,
  input  logic [25:0]  init_tag0, init_tag1, init_tag2, init_tag3, init_tag4, init_tag5, init_tag6, init_tag7,
  input  logic [25:0]  init_tag8, init_tag9, init_tag10, init_tag11, init_tag12, init_tag13, init_tag14, init_tag15,
  input  logic [25:0]  init_tag16, init_tag17, init_tag18, init_tag19, init_tag20, init_tag21, init_tag22, init_tag23,
  input  logic [25:0]  init_tag24, init_tag25, init_tag26, init_tag27, init_tag28, init_tag29, init_tag30, init_tag31,
  input  logic [127:0] init_data0, init_data1, init_data2, init_data3, init_data4, init_data5, init_data6, init_data7,
  input  logic [127:0] init_data8, init_data9, init_data10, init_data11, init_data12, init_data13, init_data14, init_data15,
  input  logic [127:0] init_data16, init_data17, init_data18, init_data19, init_data20, init_data21, init_data22, init_data23,
  input  logic [127:0] init_data24, init_data25, init_data26, init_data27, init_data28, init_data29, init_data30, init_data31,
  input  logic [2:0]   init_ctr0, init_ctr1, init_ctr2, init_ctr3, init_ctr4, init_ctr5, init_ctr6, init_ctr7,
  input  logic [2:0]   init_ctr8, init_ctr9, init_ctr10, init_ctr11, init_ctr12, init_ctr13, init_ctr14, init_ctr15,
  input  logic [2:0]   init_ctr16, init_ctr17, init_ctr18, init_ctr19, init_ctr20, init_ctr21, init_ctr22, init_ctr23,
  input  logic [2:0]   init_ctr24, init_ctr25, init_ctr26, init_ctr27, init_ctr28, init_ctr29, init_ctr30, init_ctr31,
  output logic [7:0]   dataByte_read,
  output logic         hit
);

  logic [3:0]   init_dirty_a [8];
  logic [3:0]   init_valid_a [8];
  logic [25:0]  init_tag_a   [32];
  logic [127:0] init_data_a  [32];
  logic [2:0]   init_ctr_a   [32];

  assign init_dirty_a = '{init_dirty0, init_dirty1, init_dirty2, init_dirty3,
                          init_dirty4, init_dirty5, init_dirty6, init_dirty7};
  assign init_valid_a = '{init_valid0, init_valid1, init_valid2, init_valid3,
                          init_valid4, init_valid5, init_valid6, init_valid7};
  assign init_tag_a = '{init_tag0, init_tag1, init_tag2, init_tag3, init_tag4, init_tag5, init_tag6, init_tag7,
                        init_tag8, init_tag9, init_tag10, init_tag11, init_tag12, init_tag13, init_tag14, init_tag15,
                        init_tag16, init_tag17, init_tag18, init_tag19, init_tag20, init_tag21, init_tag22, init_tag23,
                        init_tag24, init_tag25, init_tag26, init_tag27, init_tag28, init_tag29, init_tag30, init_tag31};
  assign init_data_a = '{init_data0, init_data1, init_data2, init_data3, init_data4, init_data5, init_data6, init_data7,
                         init_data8, init_data9, init_data10, init_data11, init_data12, init_data13, init_data14, init_data15,
                         init_data16, init_data17, init_data18, init_data19, init_data20, init_data21, init_data22, init_data23,
                         init_data24, init_data25, init_data26, init_data27, init_data28, init_data29, init_data30, init_data31};
  assign init_ctr_a = '{init_ctr0, init_ctr1, init_ctr2, init_ctr3, init_ctr4, init_ctr5, init_ctr6, init_ctr7,
                        init_ctr8, init_ctr9, init_ctr10, init_ctr11, init_ctr12, init_ctr13, init_ctr14, init_ctr15,
                        init_ctr16, init_ctr17, init_ctr18, init_ctr19, init_ctr20, init_ctr21, init_ctr22, init_ctr23,
                        init_ctr24, init_ctr25, init_ctr26, init_ctr27, init_ctr28, init_ctr29, init_ctr30, init_ctr31};

  logic [25:0]  tag_q   [4][8];
  logic [127:0] data_q  [4][8];
  logic [2:0]   ctr_q   [4][8];
  logic [7:0]   valid_q [4];
  logic [7:0]   dirty_q [4];

  logic [25:0]  tag_p0;
  logic [1:0]   idx_p0;
  logic [3:0]   off_p0;
  logic         rw_p0;
  logic [127:0] din_p0;
  logic [7:0]   byte_p0;
  logic [2:0]   hway_p0;
  logic [2:0]   vway_p0;
  logic         vld_p0;

  logic [7:0]   match;
  logic [2:0]   hway;
  logic [2:0]   vway;

  // Lookup: lowest matching way, and victim = lowest invalid way else the oldest (ctr 7).
  always_comb begin
    match = '0;
    hway  = '0;
    vway  = '0;
    for (int w = 0; w < 8; w++)
      match[w] = valid_q[index][w] && (tag_q[index][w] == tagIn);
    for (int w = 7; w >= 0; w--)
      if (match[w]) hway = 3'(w);
    for (int w = 7; w >= 0; w--)
      if (ctr_q[index][w] == 3'd7) vway = 3'(w);
    for (int w = 7; w >= 0; w--)
      if (!valid_q[index][w]) vway = 3'(w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 4; s++) begin
        for (int w = 0; w < 8; w++) begin
          tag_q[s][w]   <= init_tag_a[s*8 + w];
          data_q[s][w]  <= init_data_a[s*8 + w];
          ctr_q[s][w]   <= init_ctr_a[s*8 + w];
          valid_q[s][w] <= init_valid_a[w][s];
          dirty_q[s][w] <= init_dirty_a[w][s];
        end
      end
      hit           <= 1'b0;
      dataByte_read <= 8'd0;
      vld_p0        <= 1'b0;
    end else if (!cycle_en) begin
      // p0: request capture and tag compare
      tag_p0  <= tagIn;
      idx_p0  <= index;
      off_p0  <= offset;
      rw_p0   <= rw;
      din_p0  <= dataIn;
      byte_p0 <= dataByteIn;
      hit     <= |match;
      hway_p0 <= hway;
      vway_p0 <= vway;
      vld_p0  <= 1'b1;
    end else if (vld_p0) begin
      // p1: data access on hit, line fill with FIFO aging on miss
      vld_p0 <= 1'b0;
      if (hit) begin
        if (rw_p0) begin
          data_q[idx_p0][hway_p0][{off_p0, 3'b000} +: 8] <= byte_p0;
          dirty_q[idx_p0][hway_p0] <= 1'b1;
        end else begin
          dataByte_read <= data_q[idx_p0][hway_p0][{off_p0, 3'b000} +: 8];
        end
      end else begin
        for (int w = 0; w < 8; w++)
          if (ctr_q[idx_p0][w] < ctr_q[idx_p0][vway_p0])
            ctr_q[idx_p0][w] <= ctr_q[idx_p0][w] + 3'd1;
        ctr_q[idx_p0][vway_p0]   <= 3'd0;
        data_q[idx_p0][vway_p0]  <= din_p0;
        tag_q[idx_p0][vway_p0]   <= tag_p0;
        valid_q[idx_p0][vway_p0] <= 1'b1;
        dirty_q[idx_p0][vway_p0] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_8way.sv
// Scoreboard bench for cache_8way: expected hit/read byte queued per access, popped at each phase edge.
module tb_cache_8way;

  logic         clk = 1'b0;
  logic         reset;
  logic [25:0]  tagIn;
  logic [1:0]   index;
  logic [3:0]   offset;
  logic         cycle_en;
  logic         rw;
  logic [127:0] dataIn;
  logic [7:0]   dataByteIn;
  logic [7:0]   dataByte_read;
  logic         hit;

  logic [25:0]  itag   [32];
  logic [127:0] idata  [32];
  logic [2:0]   ictr   [32];
  logic [3:0]   idirty [8];
  logic [3:0]   ivalid [8];

  int checks = 0;
  int errors = 0;
  bit         hit_q [$];
  logic [7:0] rd_q  [$];

  always #5 clk = ~clk;

  cache_8way dut (
    .clk(clk), .reset(reset), .tagIn(tagIn), .index(index), .offset(offset),
    .cycle_en(cycle_en), .rw(rw), .dataIn(dataIn), .dataByteIn(dataByteIn),
    .init_dirty0(idirty[0]), .init_dirty1(idirty[1]), .init_dirty2(idirty[2]), .init_dirty3(idirty[3]),
    .init_dirty4(idirty[4]), .init_dirty5(idirty[5]), .init_dirty6(idirty[6]), .init_dirty7(idirty[7]),
    .init_valid0(ivalid[0]), .init_valid1(ivalid[1]), .init_valid2(ivalid[2]), .init_valid3(ivalid[3]),
    .init_valid4(ivalid[4]), .init_valid5(ivalid[5]), .init_valid6(ivalid[6]), .init_valid7(ivalid[7]),
    .init_tag0(itag[0]), .init_tag1(itag[1]), .init_tag2(itag[2]), .init_tag3(itag[3]),
    .init_tag4(itag[4]), .init_tag5(itag[5]), .init_tag6(itag[6]), .init_tag7(itag[7]),
    .init_tag8(itag[8]), .init_tag9(itag[9]), .init_tag10(itag[10]), .init_tag11(itag[11]),
    .init_tag12(itag[12]), .init_tag13(itag[13]), .init_tag14(itag[14]), .init_tag15(itag[15]),
    .init_tag16(itag[16]), .init_tag17(itag[17]), .init_tag18(itag[18]), .init_tag19(itag[19]),
    .init_tag20(itag[20]), .init_tag21(itag[21]), .init_tag22(itag[22]), .init_tag23(itag[23]),
    .init_tag24(itag[24]), .init_tag25(itag[25]), .init_tag26(itag[26]), .init_tag27(itag[27]),
    .init_tag28(itag[28]), .init_tag29(itag[29]), .init_tag30(itag[30]), .init_tag31(itag[31]),
    .init_data0(idata[0]), .init_data1(idata[1]), .init_data2(idata[2]), .init_data3(idata[3]),
    .init_data4(idata[4]), .init_data5(idata[5]), .init_data6(idata[6]), .init_data7(idata[7]),
    .init_data8(idata[8]), .init_data9(idata[9]), .init_data10(idata[10]), .init_data11(idata[11]),
    .init_data12(idata[12]), .init_data13(idata[13]), .init_data14(idata[14]), .init_data15(idata[15]),
    .init_data16(idata[16]), .init_data17(idata[17]), .init_data18(idata[18]), .init_data19(idata[19]),
    .init_data20(idata[20]), .init_data21(idata[21]), .init_data22(idata[22]), .init_data23(idata[23]),
    .init_data24(idata[24]), .init_data25(idata[25]), .init_data26(idata[26]), .init_data27(idata[27]),
    .init_data28(idata[28]), .init_data29(idata[29]), .init_data30(idata[30]), .init_data31(idata[31]),
    .init_ctr0(ictr[0]), .init_ctr1(ictr[1]), .init_ctr2(ictr[2]), .init_ctr3(ictr[3]),
    .init_ctr4(ictr[4]), .init_ctr5(ictr[5]), .init_ctr6(ictr[6]), .init_ctr7(ictr[7]),
    .init_ctr8(ictr[8]), .init_ctr9(ictr[9]), .init_ctr10(ictr[10]), .init_ctr11(ictr[11]),
    .init_ctr12(ictr[12]), .init_ctr13(ictr[13]), .init_ctr14(ictr[14]), .init_ctr15(ictr[15]),
    .init_ctr16(ictr[16]), .init_ctr17(ictr[17]), .init_ctr18(ictr[18]), .init_ctr19(ictr[19]),
    .init_ctr20(ictr[20]), .init_ctr21(ictr[21]), .init_ctr22(ictr[22]), .init_ctr23(ictr[23]),
    .init_ctr24(ictr[24]), .init_ctr25(ictr[25]), .init_ctr26(ictr[26]), .init_ctr27(ictr[27]),
    .init_ctr28(ictr[28]), .init_ctr29(ictr[29]), .init_ctr30(ictr[30]), .init_ctr31(ictr[31]),
    .dataByte_read(dataByte_read), .hit(hit)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Full phase pair; eb is the byte expected on dataByte_read after the data edge.
  task automatic access(input string nm, input logic [25:0] t, input logic [1:0] i, input logic [3:0] o,
                        input logic w, input logic [127:0] d, input logic [7:0] b,
                        input bit eh, input logic [7:0] eb);
    hit_q.push_back(eh);
    rd_q.push_back(eb);
    tagIn = t; index = i; offset = o; rw = w; dataIn = d; dataByteIn = b; cycle_en = 1'b0;
    @(posedge clk); #1;
    chk({nm, ".hit"}, 32'(hit), 32'(hit_q.pop_front()));
    cycle_en = 1'b1;
    @(posedge clk); #1;
    chk({nm, ".rd"}, 32'(dataByte_read), 32'(rd_q.pop_front()));
  endtask

  // Lookup edge only: observes hit without letting a fill happen.
  task automatic probe(input string nm, input logic [25:0] t, input logic [1:0] i, input bit eh);
    hit_q.push_back(eh);
    tagIn = t; index = i; offset = 4'd0; rw = 1'b0; cycle_en = 1'b0;
    @(posedge clk); #1;
    chk({nm, ".hit"}, 32'(hit), 32'(hit_q.pop_front()));
  endtask

  localparam logic [127:0] FILL_A = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    for (int n = 0; n < 32; n++) begin
      itag[n]  = 26'(1000 + n);
      idata[n] = {16{8'(n)}};
      ictr[n]  = 3'(((n % 8) + (n / 8)) % 8);
    end
    itag[4]  = 26'd130;
    itag[16] = 26'd117;
    idata[4] = 128'h21222324222324252324252624252627;
    ivalid = '{4'b1111, 4'b1101, 4'b0101, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
    idirty = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0010};

    tagIn = '0; index = '0; offset = '0; rw = 1'b0; dataIn = '0; dataByteIn = '0;
    cycle_en = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("reset.hit", 32'(hit), 32'd0);
    chk("reset.rd", 32'(dataByte_read), 32'd0);
    reset = 1'b0;

    access("rdhit15", 26'd130, 2'd0, 4'd15, 1'b0, '0, 8'h00, 1'b1, 8'h21);
    access("rdhit0",  26'd130, 2'd0, 4'd0,  1'b0, '0, 8'h00, 1'b1, 8'h27);

    access("rdmiss",  26'd256, 2'd1, 4'd13, 1'b0, '1, 8'h00, 1'b0, 8'h27);
    chk("rdmiss.ctr1_1", 32'(dut.ctr_q[1][1]), 32'd0);
    chk("rdmiss.ctr1_0", 32'(dut.ctr_q[1][0]), 32'd2);
    chk("rdmiss.ctr1_7", 32'(dut.ctr_q[1][7]), 32'd1);
    chk("rdmiss.ctr1_3", 32'(dut.ctr_q[1][3]), 32'd4);
    access("rdreiss", 26'd256, 2'd1, 4'd13, 1'b0, '0, 8'h00, 1'b1, 8'hFF);

    access("wrhit",   26'd117, 2'd2, 4'd4, 1'b1, '0, 8'h60, 1'b1, 8'hFF);
    chk("wrhit.dirty", 32'(dut.dirty_q[2][0]), 32'd1);
    access("wrback",  26'd117, 2'd2, 4'd4, 1'b0, '0, 8'h00, 1'b1, 8'h60);
    access("wrnbr",   26'd117, 2'd2, 4'd5, 1'b0, '0, 8'h00, 1'b1, 8'h10);

    access("wrmiss",  26'd257, 2'd3, 4'd0, 1'b1, '0, 8'hDD, 1'b0, 8'h10);
    chk("wrmiss.valid", 32'(dut.valid_q[3][2]), 32'd1);
    access("wrreiss", 26'd257, 2'd3, 4'd0, 1'b1, '0, 8'hDD, 1'b1, 8'h10);
    access("wrread",  26'd257, 2'd3, 4'd0, 1'b0, '0, 8'h00, 1'b1, 8'hDD);
    access("wrread1", 26'd257, 2'd3, 4'd1, 1'b0, '0, 8'h00, 1'b1, 8'h00);

    probe("fifo.pre7", 26'd1007, 2'd0, 1'b1);
    access("fifo300", 26'd300, 2'd0, 4'd3, 1'b0, FILL_A, 8'h00, 1'b0, 8'h00);
    chk("fifo.ctr0_7", 32'(dut.ctr_q[0][7]), 32'd0);
    for (int w = 0; w < 7; w++)
      chk($sformatf("fifo.ctr0_%0d", w), 32'(dut.ctr_q[0][w]), 32'(w + 1));
    probe("fifo.gone7", 26'd1007, 2'd0, 1'b0);
    probe("fifo.keep6", 26'd1006, 2'd0, 1'b1);
    access("fifo301", 26'd301, 2'd0, 4'd0, 1'b0, '1, 8'h00, 1'b0, 8'h00);
    probe("fifo.gone6", 26'd1006, 2'd0, 1'b0);
    probe("fifo.keep4", 26'd130,  2'd0, 1'b1);
    access("fifo.rd300", 26'd300, 2'd0, 4'd3, 1'b0, '0, 8'h00, 1'b1, 8'hCC);

    // Reset lands on the data edge of a pending miss.
    tagIn = 26'd302; index = 2'd0; offset = 4'd0; rw = 1'b0; dataIn = '1; cycle_en = 1'b0;
    @(posedge clk); #1;
    chk("abort.lookup", 32'(hit), 32'd0);
    reset = 1'b1; cycle_en = 1'b1;
    @(posedge clk); #1;
    chk("abort.hit", 32'(hit), 32'd0);
    chk("abort.rd", 32'(dataByte_read), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("nopend.rd", 32'(dataByte_read), 32'd0);
    chk("abort.ctr0_7", 32'(dut.ctr_q[0][7]), 32'd7);
    chk("abort.dirty2_0", 32'(dut.dirty_q[2][0]), 32'd0);
    probe("abort.p302", 26'd302, 2'd0, 1'b0);
    probe("abort.p300", 26'd300, 2'd0, 1'b0);
    probe("abort.p1007", 26'd1007, 2'd0, 1'b1);
    probe("abort.p256", 26'd256, 2'd1, 1'b0);
    access("abort.rd130", 26'd130, 2'd0, 4'd0, 1'b0, '0, 8'h00, 1'b1, 8'h27);
    access("abort.rd117", 26'd117, 2'd2, 4'd4, 1'b0, '0, 8'h00, 1'b1, 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_8way.md
# cache_8way

Phased 8-way set-associative data cache: 4 sets × 8 ways × 16-byte lines, 26-bit tag, FIFO replacement, byte-granular read/write. Every access takes a two-edge phase pair: tag lookup, then data access or line fill. Its full state (tag, data, valid, dirty, FIFO counters) is loaded synchronously from snapshot ports during reset. It has no memory-side port: the requester supplies refill data on `dataIn`, and dirty lines are tracked but never written back.

## Interface
- No parameters. Geometry is fixed: 4 sets, 8 ways, 128-bit lines, 26-bit tag.
- Line numbering: line n = set·8 + way, with set = n/8 and way = n%8.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; loads all state from the `init_*` ports.
- `tagIn` in 26: request tag.
- `index` in 2: set select.
- `offset` in 4: byte select; byte k is `line[8k+7:8k]`.
- `cycle_en` in 1: phase select; 0 = lookup edge, 1 = data edge.
- `rw` in 1: 0 = read, 1 = write.
- `dataIn` in 128: refill line, used on a miss.
- `dataByteIn` in 8: write byte.
- `init_dirty0..7` in 4 each: per way w, bit s = dirty flag of set s.
- `init_valid0..7` in 4 each: per way w, bit s = valid flag of set s.
- `init_tag0..31` in 26 each: tag of line n.
- `init_data0..31` in 128 each: data of line n.
- `init_ctr0..31` in 3 each: FIFO age of line n. Within a set the 8 values form a permutation of 0..7; 7 is oldest.
- `dataByte_read` out 8: registered read byte.
- `hit` out 1: registered hit flag.

## Operation
- Reset edge: copy every `init_*` value into state; `hit`=0; `dataByte_read`=0; clear the pending-phase latch.
- Lookup edge (reset=0, cycle_en=0):
  - latch tagIn, index, offset, rw, dataIn, dataByteIn;
  - compare tagIn against all 8 ways of `index`; match requires valid=1;
  - register `hit`, the hit way, and the victim way;
  - set the pending-phase latch.
- Victim selection: lowest-numbered invalid way; if all 8 ways are valid, the way whose ctr is 7.
- Data edge (reset=0, cycle_en=1, pending set), using latched values:
  - Read hit: `dataByte_read` ← byte[offset] of the hit line.
  - Write hit: byte[offset] ← dataByteIn; dirty=1. `dataByte_read` holds.
  - Miss (read or write):
    - victim line ← dataIn; tag ← tagIn; valid=1; dirty=0;
    - old victim age v: victim ctr ← 0; every way in the set with ctr < v increments;
    - no byte access; `dataByte_read` holds; the requester reissues the access.
  - Clear the pending-phase latch.
- Hits never change the FIFO counters.
- At most one line is written per data edge.
- A data edge with no pending lookup does nothing.

## Timing
- The requester holds the request stable from before the lookup edge through the data edge.
- Request rate: one request per 2 clocks, driven by an externally toggling cycle_en.
- `hit` is valid from the lookup edge until the next lookup edge.
- `dataByte_read` is valid from the data edge; latency is 2 edges after request setup.
- A miss costs an extra phase pair: one pair fills the line, the reissued pair hits.
- Back-to-back pairs may target the same set: the data-edge update is visible to the next lookup edge.
- Reset at any edge overrides everything and aborts a pending access with no state update.

## Test plan
Snapshot for all scenarios:
- ctr: set s way w = (w+s) mod 8.
- valid: 1111, 1101, 0101, 1011, 1111, 0111, 0111, 1111.
- dirty: 1000, 1000, 0000, 0000, 0100, 0100, 0010, 0010.
- tag4 = 130, tag16 = 117.
- data4 = 0x21222324222324252324252624252627.
- Other lines distinct.

Scenarios:
- Read hit: tag 130, idx 0, off 15 -> hit=1, `dataByte_read`=0x21. Off 0 -> 0x27.
- Read miss: tag 256, idx 1, dataIn all-FF -> hit=0; fills set 1 way 1 (first invalid); that way's ctr=0 and way 0's ctr goes 1->2. Reissue at off 13 -> hit=1, byte 0xFF.
- Write hit: tag 117, idx 2, off 4, 0x60 -> hit=1; set 2 way 0 dirty=1. Readback -> 0x60.
- Write miss: tag 257, idx 3, dataIn 0 -> hit=0; fills set 3 way 2. Reissue write of 0xDD at off 0 -> hit=1; read -> 0xDD.
- FIFO eviction in full set 0: tag 300 miss -> victim way 7 (ctr 7); ctrs become way 7 = 0, ways 0..6 = 1..7. Next miss with tag 301 -> victim way 6.
- Reset between lookup and data edge -> no state change; all `init_*` values reloaded; `hit`=0; `dataByte_read`=0.
